imem_loader: RTL and testbench
==============================

# imem_loader

Program loader on the write side of the instruction memory. Accepts a framed byte stream over a valid/ready interface, assembles big-endian 32-bit instruction words, and issues one write per word at consecutive word-aligned addresses starting at 0. While loading it holds the CPU pipeline, then releases it on a verified checksum. Replaces the fixed reset-time program image with a downloadable one.

## Interface

Parameters:
- DEPTH, 64: instruction memory depth in words; legal word count is 1..DEPTH (DEPTH ≤ 255).
- SYNC, 8'hA5: frame sync byte.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  arm loader; honoured only in IDLE, DONE, ERR.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts byte this cycle.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  32  byte address of write (word index << 2).
- wr_data  out  32  instruction word.
- cpu_hold  out  1  hold CPU in reset/stall.
- done  out  1  load completed, checksum good (level).
- err  out  1  load aborted (level).

## Operation

- Frame: SYNC, count N (8-bit), 4·N data bytes (MSB of each word first), checksum byte = XOR of all 4·N data bytes.
- Byte accepted when rx_valid & rx_ready. rx_ready is decoded from state only: 1 in SYNC, COUNT, DATA, CHECK; 0 in IDLE, DONE, ERR.
- States and transitions:
  - IDLE: cpu_hold=0. start -> SYNC.
  - SYNC: cpu_hold=1. Accepted byte == SYNC -> COUNT; any other byte discarded, stay.
  - COUNT: N==0 or N>DEPTH -> ERR; else latch N, clear word index, byte counter, checksum -> DATA.
  - DATA: shift byte into word register (word = {word[23:0], byte}), XOR into checksum. On 4th byte: schedule write of assembled word at index; increment index; if index reaches N -> CHECK else stay.
  - CHECK: accepted byte == running checksum -> DONE; else -> ERR.
  - DONE: done=1, cpu_hold=0. start -> SYNC (clears done).
  - ERR: err=1, cpu_hold=1. start -> SYNC (clears err).
- start outside IDLE/DONE/ERR ignored.
- Words written before an ERR remain in memory; err signals image invalid.
- Word index is 8-bit; never wraps since N ≤ DEPTH ≤ 255.

## Timing

- Reset (any state, mid-frame included): state IDLE, rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0, partial word, index and checksum cleared; no write issued for a partial word.
- wr_en registered: high exactly one cycle, the cycle after the 4th byte of a word is accepted; wr_addr and wr_data valid in that cycle, held afterwards until next write.
- Back-to-back bytes at one per cycle sustained; no bubbles inserted by loader. rx_valid gaps allowed at any byte position with no effect other than delay.
- cpu_hold rises the cycle after start is sampled in IDLE/DONE (entering SYNC); falls the cycle after a good checksum byte is accepted (entering DONE). Last wr_en precedes or coincides with CHECK entry, so memory is complete before cpu_hold falls.
- done/err change on the cycle after the deciding byte (or after start when clearing).
- Minimum frame latency: 2 + 4·N + 1 accepted bytes, plus 1 cycle to DONE.

## Test plan

- Reset: hold rst 2 cycles with rx_valid=1 -> all outputs 0, rx_ready=0; deassert, no start -> state stays IDLE, no bytes consumed.
- Good load: start, then A5 02 12 34 56 78 9A BC DE F0 00 at one byte/cycle -> wr_en pulses with (addr 0, 12345678) and (addr 4, 9ABCDEF0), done=1, cpu_hold 1->0, err=0.
- Bad checksum: same frame with last byte 01 -> both writes occur, err=1, done=0, cpu_hold stays 1; subsequent start + good frame -> err cleared, done=1.
- Sync hunt and gaps: start, bytes 00 FF 5A then A5 01 DE AD BE EF 22 with random rx_valid gaps -> leading bytes dropped, single write (addr 0, DEADBEEF), done=1.
- Count limits: frames with N=0 and N=DEPTH+1 -> err=1 right after count byte, no wr_en; N=DEPTH with correct checksum -> DEPTH writes, last at addr 4·(DEPTH−1), done=1.
- Reset mid-load: assert rst after 2 data bytes of word 1 -> no wr_en for that word, outputs at reset values, following start + good frame loads correctly from addr 0.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Program loader on the write side of the instruction memory.
//            Receives a framed byte stream (SYNC, count N, 4*N data bytes
//            sent MSB first, XOR checksum).  Assembles big-endian 32-bit
//            words and writes them to consecutive word addresses starting
//            at 0.  The CPU is held while a load is in progress and is
//            released only after the checksum has been verified.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start             - arm loader (honoured in IDLE/DONE/ERR)
//            rx_data/valid/ready - byte stream handshake
//            wr_en/addr/data   - one-cycle instruction-memory write
//            cpu_hold          - hold the CPU while loading / after error
//            done, err         - load result levels
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int         DEPTH = 64,
    parameter logic [7:0] SYNC  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    // Widened to 9 bits so a count byte of 255 compares correctly.
    localparam logic [8:0] c_DEPTH = 9'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_COUNT = 3'd2,
        S_DATA  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t      r_state;
    logic [7:0]  r_count;
    logic [7:0]  r_index;
    logic [1:0]  r_bytecnt;
    logic [31:0] r_word;
    logic [7:0]  r_csum;

    logic        w_accept;
    logic [31:0] w_word_next;
    logic [7:0]  w_index_next;

    // Ready depends on state only, so the sender never sees a
    // combinational path from its own valid back to ready.
    assign rx_ready = (r_state == S_SYNC)  || (r_state == S_COUNT) ||
                      (r_state == S_DATA)  || (r_state == S_CHECK);

    assign w_accept     = rx_valid & rx_ready;
    assign w_word_next  = {r_word[23:0], rx_data};
    assign w_index_next = r_index + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= 8'd0;
            r_index   <= 8'd0;
            r_bytecnt <= 2'd0;
            r_word    <= 32'd0;
            r_csum    <= 8'd0;
            wr_en     <= 1'b0;
            wr_addr   <= 32'd0;
            wr_data   <= 32'd0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_SYNC;
                        cpu_hold <= 1'b1;
                    end
                end
                S_SYNC: begin
                    // Non-sync bytes are consumed and dropped while hunting.
                    if (w_accept && (rx_data == SYNC)) begin
                        r_state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (w_accept) begin
                        if ((rx_data == 8'd0) || ({1'b0, rx_data} > c_DEPTH)) begin
                            r_state <= S_ERR;
                            err     <= 1'b1;
                        end else begin
                            r_count   <= rx_data;
                            r_index   <= 8'd0;
                            r_bytecnt <= 2'd0;
                            r_csum    <= 8'd0;
                            r_word    <= 32'd0;
                            r_state   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word    <= w_word_next;
                        r_csum    <= r_csum ^ rx_data;
                        r_bytecnt <= r_bytecnt + 2'd1;
                        if (r_bytecnt == 2'd3) begin
                            wr_en   <= 1'b1;
                            wr_addr <= {22'd0, r_index, 2'b00};
                            wr_data <= w_word_next;
                            r_index <= w_index_next;
                            if (w_index_next == r_count) begin
                                r_state <= S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        if (rx_data == r_csum) begin
                            r_state  <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            err     <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (start) begin
                        r_state  <= S_SYNC;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader.  A byte-level frame
//            interpreter predicts every output each cycle; directed frames
//            plus literal expectations on the captured write log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int         c_DEPTH = 64;
    localparam logic [7:0] c_SYNC  = 8'hA5;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    imem_loader #(.DEPTH(c_DEPTH), .SYNC(c_SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: collects the bytes of the frame being received and
    // decides outputs from the frame contents seen so far.
    // ------------------------------------------------------------------
    logic        chk_en = 1'b0;
    logic        m_ready, m_wen, m_hold, m_done, m_err;
    logic [31:0] m_addr, m_data;
    logic [7:0]  m_n;
    logic [7:0]  mq[$];
    int          s, d;
    logic [7:0]  x;

    always @(posedge clk) begin
        if (rst) begin
            chk_en  = 1'b1;
            m_ready = 1'b0; m_wen = 1'b0; m_hold = 1'b0;
            m_done  = 1'b0; m_err = 1'b0;
            m_addr  = 32'd0; m_data = 32'd0; m_n = 8'd0;
            mq.delete();
        end else if (chk_en) begin
            m_wen = 1'b0;
            if (!m_ready) begin
                if (start) begin
                    m_ready = 1'b1; m_hold = 1'b1;
                    m_done  = 1'b0; m_err  = 1'b0;
                    mq.delete();
                end
            end else if (rx_valid) begin
                s = mq.size();
                if (s == 0) begin
                    if (rx_data == c_SYNC) mq.push_back(rx_data);
                end else if (s == 1) begin
                    mq.push_back(rx_data);
                    if (rx_data == 8'd0 || int'(rx_data) > c_DEPTH) begin
                        m_ready = 1'b0; m_err = 1'b1;
                    end else begin
                        m_n = rx_data;
                    end
                end else if (s < 2 + 4 * int'(m_n)) begin
                    mq.push_back(rx_data);
                    s = mq.size();
                    d = s - 2;
                    if (d % 4 == 0) begin
                        m_wen  = 1'b1;
                        m_addr = 32'((d / 4 - 1) * 4);
                        m_data = {mq[s-4], mq[s-3], mq[s-2], mq[s-1]};
                    end
                end else begin
                    x = 8'd0;
                    for (int k = 2; k < mq.size(); k++) x = x ^ mq[k];
                    m_ready = 1'b0;
                    if (rx_data == x) begin
                        m_done = 1'b1; m_hold = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison and write capture, away from the active edge.
    logic [63:0] wlog[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("rx_ready", {63'd0, rx_ready}, {63'd0, m_ready});
            check("wr_en",    {63'd0, wr_en},    {63'd0, m_wen});
            check("wr_addr",  {32'd0, wr_addr},  {32'd0, m_addr});
            check("wr_data",  {32'd0, wr_data},  {32'd0, m_data});
            check("cpu_hold", {63'd0, cpu_hold}, {63'd0, m_hold});
            check("done",     {63'd0, done},     {63'd0, m_done});
            check("err",      {63'd0, err},      {63'd0, m_err});
            if (wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called and returning on a negative edge)
    // ------------------------------------------------------------------
    logic [7:0] fb[$];

    task automatic send_byte(input logic [7:0] b, input int gap);
        int tmo;
        repeat (gap) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        tmo = 0;
        while (rx_ready !== 1'b1 && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: rx_ready stayed %b, required 1", rx_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_fb(input int maxgap);
        foreach (fb[i]) send_byte(fb[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic good_frame();
        fb = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
               8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_outs"},
              {57'd0, rx_ready, wr_en, cpu_hold, done, err, |wr_addr, |wr_data},
              64'd0);
    endtask

    logic [7:0] cs;

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b1; rx_data = 8'hA5;

        // Reset with valid asserted, then idle without start.
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_consume", {63'd0, rx_ready}, 64'd0);
        rx_valid = 1'b0;

        // Good two-word load.
        wlog.delete();
        pulse_start();
        check("hold_after_start", {63'd0, cpu_hold}, 64'd1);
        good_frame();
        send_fb(0);
        check("good_nwr",  64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            check("good_w0", wlog[0], {32'h0, 32'h12345678});
            check("good_w1", wlog[1], {32'h4, 32'h9ABCDEF0});
        end
        check("good_flags", {61'd0, done, err, cpu_hold}, {61'd0, 3'b100});

        // Bad checksum, then recovery.
        wlog.delete();
        pulse_start();
        good_frame();
        fb[fb.size()-1] = 8'h01;
        send_fb(0);
        check("bad_nwr",   64'(wlog.size()), 64'd2);
        check("bad_flags", {61'd0, done, err, cpu_hold}, {61'd0, 3'b011});
        pulse_start();
        good_frame();
        send_fb(0);
        check("recover_flags", {61'd0, done, err, cpu_hold}, {61'd0, 3'b100});

        // Sync hunt with random gaps.
        wlog.delete();
        pulse_start();
        fb = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_fb(3);
        check("hunt_nwr", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) check("hunt_w0", wlog[0], {32'h0, 32'hDEADBEEF});
        check("hunt_done", {63'd0, done}, 64'd1);

        // Count limits.
        wlog.delete();
        pulse_start();
        fb = '{8'hA5, 8'h00};
        send_fb(0);
        check("n0_err", {62'd0, err, rx_ready}, 64'd2);
        pulse_start();
        fb = '{8'hA5, 8'(c_DEPTH + 1)};
        send_fb(0);
        check("nmax1_err", {62'd0, err, rx_ready}, 64'd2);
        check("limit_nwr", 64'(wlog.size()), 64'd0);

        pulse_start();
        fb = '{8'hA5, 8'(c_DEPTH)};
        cs = 8'd0;
        for (int i = 0; i < 4 * c_DEPTH; i++) begin
            fb.push_back(8'(i * 37 + 11));
            cs = cs ^ 8'(i * 37 + 11);
        end
        fb.push_back(cs);
        send_fb(1);
        check("full_nwr", 64'(wlog.size()), 64'(c_DEPTH));
        if (wlog.size() == c_DEPTH) check("full_last_addr", {32'd0, wlog[c_DEPTH-1][63:32]}, 64'd252);
        check("full_done", {63'd0, done}, 64'd1);

        // Reset in the middle of the first word.
        wlog.delete();
        pulse_start();
        fb = '{8'hA5, 8'h02, 8'h12, 8'h34};
        foreach (fb[i]) send_byte(fb[i], 0);
        rst = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check_idle_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        check("midrst_nwr", 64'(wlog.size()), 64'd0);
        pulse_start();
        good_frame();
        send_fb(0);
        check("midrst_reload_nwr", 64'(wlog.size()), 64'd2);
        if (wlog.size() >= 1) check("midrst_w0", wlog[0], {32'h0, 32'h12345678});
        check("midrst_done", {63'd0, done}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
